pixie_dma_scheduler: RTL and testbench

Timing and DMA sequencer for the Studio II 1861-style display path, running in CPU machine-cycle time. Counts machine cycles per line and lines per frame. Requests eight DMA-out cycles on each active line, raises the frame interrupt with CPU acknowledge, and drives the EF flag. Sits between the CDP1802 core and the video fetch/pixel logic, which consume its line/cycle/active outputs.

---
 rtl/pixie_dma_scheduler.sv | 172 +++++++++++++++++
 tb/tb_pixie_dma_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pixie_dma_scheduler.sv
// Studio II 1861-style timing and DMA sequencer. Counts CPU machine cycles per
// line and lines per frame, issues the per-line DMA-out burst, raises the frame
// interrupt and drives the EF flag ahead of the active window.
module pixie_dma_scheduler #(
  parameter int CYCLES_PER_LINE = 14,
  parameter int LINES_PER_FRAME = 262,
  parameter int INT_LINE        = 62,
  parameter int ACTIVE_START    = 64,
  parameter int ACTIVE_LINES    = 128,
  parameter int DMA_PER_LINE    = 8,
  parameter int DMA_START_CYCLE = 1,
  parameter int EF_LEAD         = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic [1:0] SC,
  input  logic       disp_on,
  input  logic       disp_off,
  output logic       DMAO,
  output logic       INT,
  output logic       EFx,
  output logic [8:0] line,
  output logic [3:0] cycle,
  output logic       active,
  output logic [3:0] dma_count,
  output logic       line_done,
  output logic       frame_start,
  output logic       dma_miss
);

  localparam logic [3:0] CYC_LAST   = 4'(CYCLES_PER_LINE - 1);
  localparam logic [3:0] DMA_START  = 4'(DMA_START_CYCLE);
  localparam logic [3:0] DMA_LAST   = 4'(DMA_PER_LINE - 1);
  localparam logic [8:0] LINE_LAST  = 9'(LINES_PER_FRAME - 1);
  localparam logic [8:0] INT_L      = 9'(INT_LINE);
  localparam logic [8:0] ACT_FIRST  = 9'(ACTIVE_START);
  localparam logic [8:0] ACT_LAST   = 9'(ACTIVE_START + ACTIVE_LINES - 1);
  localparam logic [8:0] EF1_FIRST  = 9'(ACTIVE_START - EF_LEAD);
  localparam logic [8:0] EF1_LAST   = 9'(ACTIVE_START - 1);
  localparam logic [8:0] EF2_FIRST  = 9'(ACTIVE_START + ACTIVE_LINES - EF_LEAD);

  localparam logic [1:0] SC_DMA = 2'b10;
  localparam logic [1:0] SC_INT = 2'b11;

  typedef enum logic [1:0] {IDLE, REQ, DONE} dma_state_t;

  logic [3:0] cycle_q, cycle_d;
  logic [8:0] line_q, line_d;
  logic       en_q, en_d;
  logic       active_q, active_d;
  logic       efx_q, efx_d;
  logic       frame_start_q, frame_start_d;
  logic       wrap;

  dma_state_t state_q;
  logic       dmao_q;
  logic       int_q;
  logic [3:0] dma_count_q;
  logic       line_done_q;
  logic       dma_miss_q;

  // Next-state of the raster counters, display enable and line decodes.
  always_comb begin
    cycle_d       = cycle_q;
    line_d        = line_q;
    en_d          = en_q;
    wrap          = 1'b0;
    frame_start_d = 1'b0;
    if (clk_enable) begin
      wrap    = (cycle_q == CYC_LAST);
      cycle_d = wrap ? 4'd0 : cycle_q + 4'd1;
      if (wrap) begin
        line_d        = (line_q == LINE_LAST) ? 9'd0 : line_q + 9'd1;
        frame_start_d = (line_q == LINE_LAST);
      end
      // disp_on takes priority when both strobes arrive together
      if (disp_on) en_d = 1'b1;
      else if (disp_off) en_d = 1'b0;
    end
    active_d = (line_d >= ACT_FIRST) && (line_d <= ACT_LAST);
    efx_d    = !(((line_d >= EF1_FIRST) && (line_d <= EF1_LAST)) ||
                 ((line_d >= EF2_FIRST) && (line_d <= ACT_LAST)));
  end

  // Raster counter, enable and decoded-line registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q       <= 4'd0;
      line_q        <= 9'd0;
      en_q          <= 1'b0;
      active_q      <= 1'b0;
      efx_q         <= 1'b1;
      frame_start_q <= 1'b0;
    end else begin
      cycle_q       <= cycle_d;
      line_q        <= line_d;
      en_q          <= en_d;
      active_q      <= active_d;
      efx_q         <= efx_d;
      frame_start_q <= frame_start_d;
    end
  end

  // DMA burst FSM with registered DMAO/INT, ack counter and miss flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      dmao_q      <= 1'b1;
      int_q       <= 1'b0;
      dma_count_q <= 4'd0;
      line_done_q <= 1'b0;
      dma_miss_q  <= 1'b0;
    end else begin
      line_done_q <= 1'b0;
      if (clk_enable) begin
        case (state_q)
          IDLE: begin
            if (en_d && active_d && (cycle_d == DMA_START)) begin
              state_q <= REQ;
              dmao_q  <= 1'b0;
            end
          end
          REQ: begin
            if (!en_d) begin
              // display switched off mid-burst: abandon quietly
              state_q <= IDLE;
              dmao_q  <= 1'b1;
            end else if ((SC == SC_DMA) && (dma_count_q == DMA_LAST)) begin
              dma_count_q <= dma_count_q + 4'd1;
              line_done_q <= 1'b1;
              state_q     <= DONE;
              dmao_q      <= 1'b1;
            end else begin
              if (SC == SC_DMA) dma_count_q <= dma_count_q + 4'd1;
              if (cycle_d == CYC_LAST) begin
                dma_miss_q <= 1'b1;
                state_q    <= IDLE;
                dmao_q     <= 1'b1;
              end
            end
          end
          DONE: begin
            if (wrap) state_q <= IDLE;
          end
          default: begin
            state_q <= IDLE;
            dmao_q  <= 1'b1;
          end
        endcase
        // a burst never spans a line boundary, so clearing here wins safely
        if (wrap) dma_count_q <= 4'd0;
        // frame interrupt: set beats ack/active-start clear; disable forces low
        if (!en_d) int_q <= 1'b0;
        else if (wrap && (line_d == INT_L)) int_q <= 1'b1;
        else if ((SC == SC_INT) || (wrap && (line_d == ACT_FIRST))) int_q <= 1'b0;
      end
    end
  end

  assign DMAO        = dmao_q;
  assign INT         = int_q;
  assign EFx         = efx_q;
  assign line        = line_q;
  assign cycle       = cycle_q;
  assign active      = active_q;
  assign dma_count   = dma_count_q;
  assign line_done   = line_done_q;
  assign frame_start = frame_start_q;
  assign dma_miss    = dma_miss_q;

endmodule

// File: tb/tb_pixie_dma_scheduler.sv
// Directed bench for pixie_dma_scheduler: raster timing, DMA bursts, INT, EF.
module tb_pixie_dma_scheduler;

  localparam int FRAME = 14 * 262;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_enable;
  logic [1:0] SC;
  logic       disp_on;
  logic       disp_off;
  logic       DMAO;
  logic       INT;
  logic       EFx;
  logic [8:0] line;
  logic [3:0] cycle;
  logic       active;
  logic [3:0] dma_count;
  logic       line_done;
  logic       frame_start;
  logic       dma_miss;

  int checks = 0;
  int errors = 0;
  int pos = 0;
  bit auto_ack = 1'b0;
  int ack_cap = 8;
  logic [1:0] sc_idle = 2'b00;

  pixie_dma_scheduler dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .SC(SC),
    .disp_on(disp_on), .disp_off(disp_off), .DMAO(DMAO), .INT(INT),
    .EFx(EFx), .line(line), .cycle(cycle), .active(active),
    .dma_count(dma_count), .line_done(line_done),
    .frame_start(frame_start), .dma_miss(dma_miss)
  );

  always #5 clk = ~clk;

  // One machine cycle; the CPU acks any pending DMA request unless capped.
  task automatic tick();
    SC = (auto_ack && DMAO === 1'b0 && int'(dma_count) < ack_cap) ? 2'b10 : sc_idle;
    clk_enable = 1'b1;
    @(posedge clk); #1;
    pos = (pos + 1) % FRAME;
    disp_on = 1'b0;
    disp_off = 1'b0;
    sc_idle = 2'b00;
  endtask

  task automatic goto(input int l, input int c);
    int n;
    n = (l * 14 + c - pos + FRAME) % FRAME;
    repeat (n) tick();
    checks++;
    if (line !== 9'(l) || cycle !== 4'(c)) begin
      errors++;
      $display("FAIL goto: got line %0d cycle %0d required line %0d cycle %0d", line, cycle, l, c);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    pos = 0;
  endtask

  task automatic chk(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, req);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_dmao"}, int'(DMAO), 1);
    chk({tag, "_int"}, int'(INT), 0);
    chk({tag, "_efx"}, int'(EFx), 1);
    chk({tag, "_line"}, int'(line), 0);
    chk({tag, "_cycle"}, int'(cycle), 0);
    chk({tag, "_dma_count"}, int'(dma_count), 0);
    chk({tag, "_dma_miss"}, int'(dma_miss), 0);
    chk({tag, "_active"}, int'(active), 0);
    chk({tag, "_frame_start"}, int'(frame_start), 0);
    chk({tag, "_line_done"}, int'(line_done), 0);
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_state("reset");
  endtask

  // Runs one full frame from line 0 cycle 0 and tallies deviations.
  task automatic run_frame(input string tag, input bit en);
    int m_pos, m_ef, m_act, m_dmao, m_int, n_ld, n_fs, l, c;
    logic e_ef, e_act, e_dmao, e_int;
    m_pos = 0; m_ef = 0; m_act = 0; m_dmao = 0; m_int = 0; n_ld = 0; n_fs = 0;
    for (int i = 0; i < FRAME; i++) begin
      tick();
      l = pos / 14;
      c = pos % 14;
      e_ef   = !((l >= 60 && l <= 63) || (l >= 188 && l <= 191));
      e_act  = (l >= 64 && l <= 191);
      e_dmao = !(en && e_act && c >= 1 && c <= 8);
      e_int  = en && (l == 62 || l == 63);
      if (line !== 9'(l) || cycle !== 4'(c)) m_pos++;
      if (EFx !== e_ef) m_ef++;
      if (active !== e_act) m_act++;
      if (DMAO !== e_dmao) m_dmao++;
      if (INT !== e_int) m_int++;
      if (line_done === 1'b1) n_ld++;
      if (frame_start === 1'b1) n_fs++;
    end
    chk({tag, "_pos_mismatches"}, m_pos, 0);
    chk({tag, "_efx_mismatches"}, m_ef, 0);
    chk({tag, "_active_mismatches"}, m_act, 0);
    chk({tag, "_dmao_mismatches"}, m_dmao, 0);
    chk({tag, "_int_mismatches"}, m_int, 0);
    chk({tag, "_line_done_pulses"}, n_ld, en ? 128 : 0);
    chk({tag, "_frame_start_pulses"}, n_fs, 1);
    chk({tag, "_frame_start_at_wrap"}, int'(frame_start), 1);
    chk({tag, "_dma_miss"}, int'(dma_miss), 0);
  endtask

  task automatic test_disabled_frame();
    run_frame("disabled", 1'b0);
  endtask

  task automatic test_enabled_frame();
    auto_ack = 1'b1;
    ack_cap = 8;
    disp_on = 1'b1;
    run_frame("enabled", 1'b1);
  endtask

  task automatic test_int_ack();
    goto(62, 5);
    chk("int_raised", int'(INT), 1);
    sc_idle = 2'b11;
    tick();
    chk("int_acked", int'(INT), 0);
    goto(64, 0);
    chk("int_stays_clear", int'(INT), 0);
  endtask

  task automatic test_miss();
    goto(100, 0);
    ack_cap = 5;
    goto(100, 12);
    chk("miss_pending_count", int'(dma_count), 5);
    chk("miss_pending_dmao", int'(DMAO), 0);
    chk("miss_not_yet", int'(dma_miss), 0);
    tick();
    chk("miss_flag", int'(dma_miss), 1);
    chk("miss_dmao_release", int'(DMAO), 1);
    ack_cap = 8;
    goto(101, 8);
    chk("next_line_count7", int'(dma_count), 7);
    chk("next_line_dmao", int'(DMAO), 0);
    tick();
    chk("next_line_done", int'(line_done), 1);
    chk("next_line_count8", int'(dma_count), 8);
    chk("next_line_dmao_high", int'(DMAO), 1);
    chk("miss_sticky", int'(dma_miss), 1);
    tick();
    chk("line_done_one_clk", int'(line_done), 0);
  endtask

  task automatic test_reset_mid_burst();
    goto(70, 4);
    chk("burst_count3", int'(dma_count), 3);
    chk("burst_dmao_low", int'(DMAO), 0);
    do_reset();
    check_reset_state("mid_reset");
  endtask

  task automatic test_disp_off();
    int lows;
    disp_on = 1'b1;
    tick();
    goto(80, 4);
    chk("off_count3", int'(dma_count), 3);
    chk("off_dmao_low", int'(DMAO), 0);
    disp_off = 1'b1;
    tick();
    chk("off_dmao_high", int'(DMAO), 1);
    chk("off_no_miss", int'(dma_miss), 0);
    lows = 0;
    for (int i = 0; i < 20 * 14; i++) begin
      tick();
      if (DMAO === 1'b0) lows++;
    end
    chk("off_no_more_dmao", lows, 0);
    chk("off_no_miss_later", int'(dma_miss), 0);
    chk("off_int_low", int'(INT), 0);
  endtask

  task automatic test_enable_gap();
    disp_on = 1'b1;
    clk_enable = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    disp_on = 1'b0;
    chk("gap_line_held", int'(line), 100);
    chk("gap_cycle_held", int'(cycle), 5);
    goto(101, 3);
    chk("gap_strobe_ignored", int'(DMAO), 1);
    disp_on = 1'b1;
    disp_off = 1'b1;
    tick();
    goto(102, 2);
    chk("both_strobes_on_wins", int'(DMAO), 0);
    chk("both_strobes_count", int'(dma_count), 1);
  endtask

  initial begin
    reset = 1'b0;
    clk_enable = 1'b0;
    SC = 2'b00;
    disp_on = 1'b0;
    disp_off = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_disabled_frame();
    test_enabled_frame();
    test_int_ack();
    test_miss();
    test_reset_mid_burst();
    test_disp_off();
    test_enable_gap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
